md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
Multiply/divide unit in the E stage of the 5-stage MIPS pipeline. Executes mult/multu/div/divu with fixed multi-cycle latency and holds HI/LO. Serves mfhi/mflo/mthi/mtlo. Produces the MDStall signal that the E pipeline register consumes to insert bubbles. Honours Req (exception/interrupt flush), so a flushed E-stage instruction never modifies HI/LO.

Parameters:
MULT_CYCLES, 5, Busy cycles for mult/multu (1..15).
DIV_CYCLES, 10, Busy cycles for div/divu (1..15).

Ports:
Clk  input  1  clock.
Reset  input  1  synchronous, active-high reset.
Req  input  1  exception/interrupt flush; cancels the E-stage operation presented this cycle.
Start  input  1  E-stage instruction is an MD op (decoded from MDOp != MD_NONE and not a bubble).
MDOp  input  4  operation code (package enum).
A  input  32  rs operand (forwarded).
B  input  32  rt operand (forwarded).
DIsMD  input  1  D-stage instruction is any MD-class op.
Busy  output  1  multi-cycle operation in progress.
MDStall  output  1  stall request to D/E pipeline registers.
HI  output  32  HI register.
LO  output  32  LO register.
MDOut  output  32  read data for mfhi/mflo.

Behaviour:
- Reset: HI=0, LO=0, Busy=0, state IDLE, counter=0. Reset mid-operation aborts it; no HI/LO update.
- States: IDLE, BUSY. Counter is 4 bits.
- IDLE to BUSY: at a clock edge with Start & !Req & MDOp in {MULT,MULTU,DIV,DIVU}. Operands and op are latched; counter loads MULT_CYCLES-1 or DIV_CYCLES-1.
- Busy is high exactly N cycles after the start edge. At the edge ending the last Busy cycle (counter==0), HI/LO are written, and state returns to IDLE. New HI/LO are visible the cycle Busy falls.
- Arithmetic: MULT is the signed 32x32 product; MULTU is unsigned; {HI,LO}=64-bit product.
- DIV is signed with quotient truncated toward zero: LO=quotient, HI=remainder, with remainder sign = dividend sign. DIVU is unsigned.
- Divide by zero: HI/LO are left unchanged at completion; Busy timing is unchanged.
- 0x80000000 / -1 (signed): LO=0x80000000, HI=0.
- MTHI/MTLO: HI or LO <= A at the edge when Start & !Req & IDLE. No Busy.
- MFHI/MFLO: MDOut = HI or LO combinationally; MDOut = 0 for any other op.
- Req while Start: nothing starts or writes; state is unchanged.
- Req while BUSY: the running op is older than the faulting instruction and completes normally.
- Start while BUSY cannot occur because of the stall. If it does, it is ignored.
- MDStall = DIsMD & (Busy | (Start & MDOp in {MULT,MULTU,DIV,DIVU})). Combinational.
- The E register turns MDStall into a bubble: it zeroes ctrl and keeps PC.

Optional Feature:
MD_MADD_EN:
- Defined: MADD/MADDU/MSUB/MSUBU are added (MULT_CYCLES latency). Completion computes {HI,LO} = {HI,LO} +/- product. The product is signed for MADD/MSUB and unsigned for MADDU/MSUBU. The accumulate reads HI/LO at completion.
- Undefined: these codes behave as MD_NONE (no start, no stall).

Decomposition:
- Shared package, alongside the existing CTRL_LEN/control-bit definitions: MDOp enum values MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
- Also in the package: the helper "is multi-cycle op" constant set.
- One sub-module, md_divider_core: combinational signed/unsigned quotient/remainder with the zero and overflow rules. The multiplier stays inline.

Test Plan:
- MULT A=0xFFFFFFFD, B=5 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIVU 7/2 -> Busy 10 cycles; LO=3, HI=1. DIV 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI A=0x1234 with Req=1 -> HI unchanged. Same with Req=0 -> HI=0x1234 next cycle, Busy stays 0.
- MULT Start with Req=1 -> Busy never rises, HI/LO unchanged. Req pulse at Busy cycle 3 of a DIV -> DIV completes with the correct result.
- DIV with B=0 after HI=0xAA, LO=0xBB -> Busy 10 cycles, HI/LO stay 0xAA/0xBB. Reset at Busy cycle 2 -> Busy=0, HI=LO=0.
- DIsMD=1 during Busy -> MDStall=1 every Busy cycle and 0 the cycle Busy falls. DIsMD=1 on the Start cycle of MULT -> MDStall=1. DIsMD=0 -> MDStall=0.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared MD-unit definitions: MDOp encoding and op-class helpers.
// MD_MADD_EN adds the multiply-accumulate ops to the multi-cycle set.
package md_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MFHI    = 4'd5,
    MFLO    = 4'd6,
    MTHI    = 4'd7,
    MTLO    = 4'd8,
    MADD    = 4'd9,
    MADDU   = 4'd10,
    MSUB    = 4'd11,
    MSUBU   = 4'd12
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // Ops that occupy the unit for several cycles and stall dependent MD ops.
  function automatic logic is_multi_cycle(input md_op_e op);
    case (op)
      MULT, MULTU, DIV, DIVU: return 1'b1;
`ifdef MD_MADD_EN
      MADD, MADDU, MSUB, MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic is_signed_mul(input md_op_e op);
    return (op == MULT) || (op == MADD) || (op == MSUB);
  endfunction

endpackage

// File: rtl/md_divider_core.sv
// Combinational 32-bit divider: signed (truncating) or unsigned quotient and
// remainder, with divide-by-zero flag and the INT_MIN / -1 overflow case.
module md_divider_core
  import md_unit_pkg::*;
(
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  logic        neg_n;
  logic        neg_d;
  logic [31:0] mag_n;
  logic [31:0] mag_d;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  always_comb begin
    neg_n       = is_signed & dividend[31];
    neg_d       = is_signed & divisor[31];
    mag_n       = neg_n ? (~dividend + 32'd1) : dividend;
    mag_d       = neg_d ? (~divisor + 32'd1) : divisor;
    div_by_zero = (divisor == 32'd0);
    // Substitute 1 for a zero divisor so the divide never sees X; result is discarded.
    if (div_by_zero) mag_d = 32'd1;
    q_mag       = mag_n / mag_d;
    r_mag       = mag_n % mag_d;
    quotient    = (neg_n ^ neg_d) ? (~q_mag + 32'd1) : q_mag;
    remainder   = neg_n ? (~r_mag + 32'd1) : r_mag;
    if (is_signed && dividend == 32'h8000_0000 && divisor == 32'hFFFF_FFFF) begin
      quotient  = 32'h8000_0000;
      remainder = 32'd0;
    end
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: fixed-latency mult/div, HI/LO, MDStall.
// Define MD_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulate ops.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        DIsMD,
  output logic        Busy,
  output logic        MDStall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  md_state_e   state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  md_op_e      op_reg, op_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;

  md_op_e      op_in;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  assign op_in = md_op_e'(MDOp);

  // Sign/zero-extend to 64 bits so one unsigned multiplier serves both flavours.
  always_comb begin
    a_ext   = is_signed_mul(op_reg) ? {{32{a_reg[31]}}, a_reg} : {32'd0, a_reg};
    b_ext   = is_signed_mul(op_reg) ? {{32{b_reg[31]}}, b_reg} : {32'd0, b_reg};
    product = a_ext * b_ext;
  end

  md_divider_core u_div (
    .dividend    (a_reg),
    .divisor     (b_reg),
    .is_signed   (op_reg == DIV),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      op_reg    <= MD_NONE;
      a_reg     <= 32'd0;
      b_reg     <= 32'd0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    case (state_reg)
      IDLE: begin
        if (Start && !Req) begin
          if (is_multi_cycle(op_in)) begin
            state_next = BUSY;
            cnt_next   = is_div_op(op_in) ? DIV_LOAD : MULT_LOAD;
            op_next    = op_in;
            a_next     = A;
            b_next     = B;
          end else if (op_in == MTHI) begin
            hi_next = A;
          end else if (op_in == MTLO) begin
            lo_next = A;
          end
        end
      end
      BUSY: begin
        // Start is ignored here; Req only flushes younger ops, so this one finishes.
        if (cnt_reg == 4'd0) begin
          state_next = IDLE;
          case (op_reg)
            MULT, MULTU: {hi_next, lo_next} = product;
            DIV, DIVU: begin
              if (!div_by_zero) begin
                hi_next = remainder;
                lo_next = quotient;
              end
            end
`ifdef MD_MADD_EN
            MADD, MADDU: {hi_next, lo_next} = {hi_reg, lo_reg} + product;
            MSUB, MSUBU: {hi_next, lo_next} = {hi_reg, lo_reg} - product;
`endif
            default: ;
          endcase
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign Busy    = (state_reg == BUSY);
  assign HI      = hi_reg;
  assign LO      = lo_reg;
  assign MDStall = DIsMD & (Busy | (Start & is_multi_cycle(op_in)));

  always_comb begin
    case (op_in)
      MFHI:    MDOut = hi_reg;
      MFLO:    MDOut = lo_reg;
      default: MDOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: scoreboard of expected HI/LO per op.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, Req, Start, DIsMD;
  logic [3:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy, MDStall;
  logic [31:0] HI, LO, MDOut;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Start(Start), .MDOp(MDOp),
    .A(A), .B(B), .DIsMD(DIsMD), .Busy(Busy), .MDStall(MDStall),
    .HI(HI), .LO(LO), .MDOut(MDOut)
  );

  always #5 Clk = ~Clk;

  // Drive one Start cycle; returns #1 after the start edge.
  task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic req);
    @(negedge Clk);
    Start = 1'b1; MDOp = op; A = a; B = b; Req = req;
    @(posedge Clk); #1;
    Start = 1'b0; MDOp = MD_NONE; Req = 1'b0;
  endtask

  // Count Busy cycles (bounded); leaves us #1 after the edge where Busy fell.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (Busy && cycles < 40) begin
      cycles++;
      @(posedge Clk); #1;
    end
  endtask

  task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   cyc;
    issue(op, a, b, 1'b0);
    wait_idle(cyc);
    e = sb.pop_front();
    checks++;
    if (cyc !== e.cycles) begin
      errors++; $display("FAIL %s busy_cycles got %0d want %0d", e.name, cyc, e.cycles);
    end
    checks++;
    if (HI !== e.hi || LO !== e.lo) begin
      errors++;
      $display("FAIL %s hilo got %h_%h want %h_%h", e.name, HI, LO, e.hi, e.lo);
    end
    $display("%s a=%h b=%h -> HI=%h LO=%h cycles=%0d", e.name, a, b, HI, LO, cyc);
  endtask

  task automatic test_reset();
    Reset = 1'b1; Req = 0; Start = 0; MDOp = MD_NONE; A = 0; B = 0; DIsMD = 0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    checks++;
    if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0 || MDStall !== 1'b0) begin
      errors++;
      $display("FAIL reset got HI=%h LO=%h Busy=%b Stall=%b want 0", HI, LO, Busy, MDStall);
    end
    $display("reset HI=%h LO=%h Busy=%b", HI, LO, Busy);
  endtask

  task automatic test_mult();
    sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFF1, 5, "mult_neg3x5"});
    run_op(MULT, 32'hFFFF_FFFD, 32'd5);
    MDOp = MFHI; #1;
    checks++;
    if (MDOut !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL mfhi got %h want ffffffff", MDOut);
    end
    MDOp = MFLO; #1;
    checks++;
    if (MDOut !== 32'hFFFF_FFF1) begin
      errors++; $display("FAIL mflo got %h want fffffff1", MDOut);
    end
    MDOp = MULT; #1;
    checks++;
    if (MDOut !== 32'd0) begin
      errors++; $display("FAIL mdout_other got %h want 0", MDOut);
    end
    MDOp = MD_NONE;
    $display("mfhi/mflo/other readback checked");
    sb.push_back('{32'hFFFF_FFFE, 32'h0000_0001, 5, "multu_max"});
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_div();
    sb.push_back('{32'd1, 32'd3, 10, "divu_7_2"});
    run_op(DIVU, 32'd7, 32'd2);
    sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div_neg7_2"});
    run_op(DIV, 32'hFFFF_FFF9, 32'd2);
    sb.push_back('{32'd1, 32'hFFFF_FFFD, 10, "div_7_neg2"});
    run_op(DIV, 32'd7, 32'hFFFF_FFFE);
    sb.push_back('{32'd0, 32'h8000_0000, 10, "div_ovf"});
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [63:0] p;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      p = {32'd0, a} * {32'd0, b};
      sb.push_back('{p[63:32], p[31:0], 5, "multu_rand"});
      run_op(MULTU, a, b);
      b = b >> (i * 7);
      if (b == 0) b = 32'd3;
      sb.push_back('{a % b, a / b, 10, "divu_rand"});
      run_op(DIVU, a, b);
    end
  endtask

  task automatic test_mthi_req();
    logic [31:0] hi0;
    hi0 = HI;
    issue(MTHI, 32'h1234, 32'd0, 1'b1);
    checks++;
    if (HI !== hi0) begin
      errors++; $display("FAIL mthi_req got %h want %h", HI, hi0);
    end
    $display("mthi req=1 HI=%h", HI);
    issue(MTHI, 32'h1234, 32'd0, 1'b0);
    checks++;
    if (HI !== 32'h1234 || Busy !== 1'b0) begin
      errors++; $display("FAIL mthi got HI=%h Busy=%b want 00001234 0", HI, Busy);
    end
    $display("mthi req=0 HI=%h Busy=%b", HI, Busy);
  endtask

  task automatic test_mult_req();
    logic [31:0] hi0, lo0;
    logic        seen;
    hi0 = HI; lo0 = LO; seen = 1'b0;
    issue(MULT, 32'd9, 32'd9, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (Busy) seen = 1'b1;
      @(posedge Clk); #1;
    end
    checks++;
    if (seen || HI !== hi0 || LO !== lo0) begin
      errors++;
      $display("FAIL mult_req got busy=%b HI=%h LO=%h want 0 %h %h", seen, HI, LO, hi0, lo0);
    end
    $display("mult req=1 busy_seen=%b HI=%h LO=%h", seen, HI, LO);
  endtask

  task automatic test_div_req_mid();
    exp_t e;
    int   cyc;
    sb.push_back('{32'd2, 32'd14, 10, "div_req_mid"});
    issue(DIV, 32'd100, 32'd7, 1'b0);
    cyc = 0;
    while (Busy && cyc < 40) begin
      cyc++;
      Req = (cyc == 3);
      @(posedge Clk); #1;
    end
    Req = 1'b0;
    e = sb.pop_front();
    checks++;
    if (cyc !== e.cycles || HI !== e.hi || LO !== e.lo) begin
      errors++;
      $display("FAIL %s got cyc=%0d HI=%h LO=%h want %0d %h %h", e.name, cyc, HI, LO,
               e.cycles, e.hi, e.lo);
    end
    $display("%s HI=%h LO=%h cycles=%0d", e.name, HI, LO, cyc);
  endtask

  task automatic test_div_zero();
    issue(MTHI, 32'hAA, 32'd0, 1'b0);
    issue(MTLO, 32'hBB, 32'd0, 1'b0);
    sb.push_back('{32'hAA, 32'hBB, 10, "div_by_zero"});
    run_op(DIV, 32'd55, 32'd0);
  endtask

  task automatic test_reset_mid();
    issue(DIV, 32'd50, 32'd5, 1'b0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    checks++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++; $display("FAIL reset_mid got Busy=%b HI=%h LO=%h want 0 0 0", Busy, HI, LO);
    end
    repeat (12) @(posedge Clk);
    #1;
    checks++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++; $display("FAIL reset_mid_late got Busy=%b HI=%h LO=%h want 0 0 0", Busy, HI, LO);
    end
    $display("reset mid-div Busy=%b HI=%h LO=%h", Busy, HI, LO);
  endtask

  task automatic test_stall();
    int cyc;
    int bad;
    @(negedge Clk);
    DIsMD = 1'b1; Start = 1'b1; MDOp = MULT; A = 32'd3; B = 32'd4;
    #1;
    checks++;
    if (MDStall !== 1'b1) begin
      errors++; $display("FAIL stall_start got %b want 1", MDStall);
    end
    @(posedge Clk); #1;
    Start = 1'b0; MDOp = MD_NONE;
    cyc = 0; bad = 0;
    while (Busy && cyc < 40) begin
      cyc++;
      if (MDStall !== 1'b1) bad++;
      @(posedge Clk); #1;
    end
    checks++;
    if (bad != 0 || cyc != 5) begin
      errors++; $display("FAIL stall_busy got misses=%0d cyc=%0d want 0 5", bad, cyc);
    end
    checks++;
    if (MDStall !== 1'b0) begin
      errors++; $display("FAIL stall_fall got %b want 0", MDStall);
    end
    checks++;
    if (HI !== 32'd0 || LO !== 32'd12) begin
      errors++; $display("FAIL stall_result got %h_%h want 0_c", HI, LO);
    end
    $display("stall DIsMD=1 busy_cycles=%0d misses=%0d", cyc, bad);
    DIsMD = 1'b0;
    issue(DIVU, 32'd9, 32'd3, 1'b0);
    bad = 0; cyc = 0;
    while (Busy && cyc < 40) begin
      cyc++;
      if (MDStall !== 1'b0) bad++;
      @(posedge Clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_nodis got %0d stalled cycles want 0", bad);
    end
    $display("stall DIsMD=0 stalled=%0d", bad);
  endtask

  task automatic test_back_to_back();
    sb.push_back('{32'd0, 32'd42, 5, "b2b_mult"});
    sb.push_back('{32'd4, 32'd6, 10, "b2b_divu"});
    run_op(MULT, 32'd6, 32'd7);
    run_op(DIVU, 32'd46, 32'd7);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_req();
    test_mult_req();
    test_div_req_mid();
    test_div_zero();
    test_reset_mid();
    test_stall();
    test_back_to_back();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
